// File: rtl/wam_pkg.sv
// Shared encodings, limits and state types for the whack-a-mole scoring datapath.
package wam_pkg;

    localparam logic [2:0] MODE_POINTS = 3'b100;
    localparam logic [2:0] MODE_TIMED  = 3'b010;
    localparam logic [2:0] MODE_LIVES  = 3'b001;

    localparam logic [3:0] MAX_LIVES = 4'd9;
    localparam logic [3:0] MIN_LIVES = 4'd1;

    typedef enum logic [1:0] {
        GameIdle,
        GameRun,
        GameOver
    } game_state_e;

    typedef enum logic [1:0] {
        WinClosed,
        WinArmed,
        WinJudged
    } win_state_e;

    function automatic logic [3:0] clamp_lives(input logic [3:0] n);
        if (n < MIN_LIVES) begin
            return MIN_LIVES;
        end else if (n > MAX_LIVES) begin
            return MAX_LIVES;
        end
        return n;
    endfunction

endpackage

// File: rtl/window_judge.sv
// Judging window per lit light: latches the target, detects press edges and
// emits one-cycle good/bad/miss/open strobes for the counters in score_keeper.
module window_judge
    import wam_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic       light_change_i,
    input  logic [3:0] light_pos_i,
    input  logic       key_down_i,
    input  logic [3:0] key_pressed_i,
    output logic       good_o,
    output logic       bad_o,
    output logic       miss_o,
    output logic       open_o,
    output win_state_e state_o
);

    win_state_e state_q, state_d;
    logic [3:0] target_q, target_d;
    logic       key_q;
    logic       press;

    // The edge detector samples even while judging is paused, so a key already
    // held when play resumes never produces an edge.
    assign press = key_down_i & ~key_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= WinClosed;
            target_q <= 4'd0;
            key_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            key_q    <= key_down_i;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        if (clear_i) begin
            state_d = WinClosed;
        end else if (en_i) begin
            unique case (state_q)
                WinClosed, WinJudged: begin
                    if (light_change_i) begin
                        state_d  = WinArmed;
                        target_d = light_pos_i;
                    end
                end
                WinArmed: begin
                    if (light_change_i) begin
                        target_d = light_pos_i;
                    end else if (press) begin
                        state_d = WinJudged;
                    end
                end
                default: state_d = WinClosed;
            endcase
        end
    end

    always_comb begin
        good_o = 1'b0;
        bad_o  = 1'b0;
        miss_o = 1'b0;
        open_o = 1'b0;
        if (!clear_i && en_i) begin
            open_o = light_change_i;
            if (state_q == WinArmed) begin
                good_o = press && (key_pressed_i == target_q);
                bad_o  = press && (key_pressed_i != target_q);
                miss_o = light_change_i && !press;
            end
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/score_keeper.sv
// Game FSM, points/lives/time/window counters and end-of-game detection
// layered on top of the window_judge grading strobes.
module score_keeper
    import wam_pkg::*;
#(
    parameter int unsigned TIME_SECS       = 60,
    parameter bit          MISS_COSTS_LIFE = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       active_i,
    input  logic [2:0] mode_i,
    input  logic [5:0] max_hits_i,
    input  logic [3:0] total_lives_i,
    input  logic       tick_1hz_i,
    input  logic       light_change_i,
    input  logic [3:0] light_pos_i,
    input  logic       key_down_i,
    input  logic [3:0] key_pressed_i,
    output logic [5:0] points_o,
    output logic [3:0] lives_left_o,
    output logic [5:0] time_left_o,
    output logic [5:0] windows_o,
    output logic       hit_o,
    output logic       game_over_o
);

    game_state_e game_q, game_d;
    logic [2:0]  mode_q, mode_d;
    logic [5:0]  points_q, points_d;
    logic [3:0]  lives_q, lives_d;
    logic [5:0]  time_q, time_d;
    logic [5:0]  windows_q, windows_d;
    logic        hit_q, hit_d;
    logic        over_q, over_d;

    logic        run_en, end_now, lose_life;
    logic        is_points, is_timed, is_lives;
    logic        good, bad, miss, open_win;
    win_state_e  win_state;

    assign run_en    = (game_q == GameRun) && active_i && !start_i;
    assign is_timed  = (mode_q == MODE_TIMED);
    assign is_lives  = (mode_q == MODE_LIVES);
    assign is_points = !is_timed && !is_lives;
    assign lose_life = is_lives && (bad || (miss && MISS_COSTS_LIFE));

    window_judge u_judge (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (start_i),
        .en_i           (run_en),
        .light_change_i (light_change_i),
        .light_pos_i    (light_pos_i),
        .key_down_i     (key_down_i),
        .key_pressed_i  (key_pressed_i),
        .good_o         (good),
        .bad_o          (bad),
        .miss_o         (miss),
        .open_o         (open_win),
        .state_o        (win_state)
    );

    // End conditions look at registered counters, so the flag lags the update by one edge.
    always_comb begin
        end_now = 1'b0;
        if (game_q == GameRun && !start_i) begin
            end_now = (is_points && windows_q == max_hits_i &&
                       (win_state == WinJudged || (run_en && light_change_i))) ||
                      (is_timed && time_q == 6'd0) ||
                      (is_lives && lives_q == 4'd0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            game_q    <= GameIdle;
        end else begin
            game_q    <= game_d;
        end
    end

    always_comb begin
        game_d = game_q;
        if (start_i) begin
            game_d = GameRun;
        end else if (game_q == GameRun && end_now) begin
            game_d = GameOver;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q    <= MODE_POINTS;
            points_q  <= 6'd0;
            lives_q   <= 4'd0;
            time_q    <= 6'd0;
            windows_q <= 6'd0;
            hit_q     <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            points_q  <= points_d;
            lives_q   <= lives_d;
            time_q    <= time_d;
            windows_q <= windows_d;
            hit_q     <= hit_d;
            over_q    <= over_d;
        end
    end

    always_comb begin
        mode_d    = mode_q;
        points_d  = points_q;
        lives_d   = lives_q;
        time_d    = time_q;
        windows_d = windows_q;
        hit_d     = good;
        over_d    = over_q;
        if (start_i) begin
            mode_d    = (mode_i == MODE_TIMED || mode_i == MODE_LIVES) ? mode_i : MODE_POINTS;
            points_d  = 6'd0;
            lives_d   = clamp_lives(total_lives_i);
            time_d    = 6'(TIME_SECS);
            windows_d = 6'd0;
            hit_d     = 1'b0;
            over_d    = 1'b0;
        end else begin
            if (run_en) begin
                if (good && points_q != 6'd63) begin
                    points_d = points_q + 6'd1;
                end
                if (lose_life && lives_q != 4'd0) begin
                    lives_d = lives_q - 4'd1;
                end
                // A light arriving as the game ends is not counted as a new window.
                if (open_win && !end_now && windows_q != 6'd63) begin
                    windows_d = windows_q + 6'd1;
                end
                if (is_timed && tick_1hz_i && time_q != 6'd0) begin
                    time_d = time_q - 6'd1;
                end
            end
            if (end_now) begin
                over_d = 1'b1;
            end
        end
    end

    assign points_o     = points_q;
    assign lives_left_o = lives_q;
    assign time_left_o  = time_q;
    assign windows_o    = windows_q;
    assign hit_o        = hit_q;
    assign game_over_o  = over_q;

endmodule
